// File: rtl/bounce_gen_pkg.sv
// ============================================================================
// Module   : bounce_gen_pkg
// Brief    : Shared types and constants for the contact-bounce generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bounce_gen_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHATTER = 2'd1,
        SETTLE  = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;

    // Right-shifting Galois step; the bit shifted out selects the tap mask.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bounce_generator_lfsr16.sv
// ============================================================================
// Module   : lfsr16
// Brief    : Free-running 16-bit Galois LFSR with synchronous reseed.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr16
    import bounce_gen_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_LFSR_SEED
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    output logic [15:0] o_State
);

    logic [15:0] r_state;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state <= SEED;
        end else begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign o_State = r_state;

endmodule

`default_nettype wire

// File: rtl/bounce_generator.sv
// ============================================================================
// Module   : bounce_generator
// Brief    : Contact-bounce emulator: target edge, LFSR-spaced chatter pairs,
//            settle window, done pulse. Option macro: BOUNCE_GEN_RANDPAIRS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bounce_generator
    import bounce_gen_pkg::*;
#(
    parameter int          BOUNCE_PAIRS  = 3,
    parameter int          MIN_GAP       = 2,
    parameter int          GAP_BITS      = 3,
    parameter int          SETTLE_CYCLES = 32,
    parameter logic        INIT_LEVEL    = 1'b0,
    parameter logic [15:0] LFSR_SEED     = DEFAULT_LFSR_SEED
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Req,
    input  logic i_Level,
    output logic o_Ready,
    output logic o_Busy,
    output logic o_Done,
    output logic o_Bouncy
);

    localparam int GAP_W    = $clog2(MIN_GAP + 2**GAP_BITS + 1);
    localparam int TOG_W    = (BOUNCE_PAIRS > 0) ? $clog2(2*BOUNCE_PAIRS + 1) : 1;
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_bouncy;
    logic                 r_done;
    logic [GAP_W-1:0]     r_gap_cnt;
    logic [TOG_W-1:0]     r_toggles_left;
    logic [SETTLE_W-1:0]  r_settle_cnt;
    logic [15:0]          w_lfsr;
    logic [GAP_W-1:0]     w_gap;
    logic [TOG_W-1:0]     w_toggles_init;
    logic                 w_accept;
    logic                 w_change;
    logic                 w_toggle;
    logic                 w_last_toggle;
    logic                 w_unused_lfsr;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .o_State (w_lfsr)
    );

    assign w_gap         = GAP_W'(MIN_GAP) + GAP_W'(w_lfsr[GAP_BITS-1:0]);
    assign w_accept      = i_Req && (r_state == IDLE);
    assign w_change      = (i_Level != r_bouncy);
    assign w_toggle      = (r_state == CHATTER) && (r_gap_cnt == GAP_W'(1));
    assign w_last_toggle = w_toggle && (r_toggles_left == TOG_W'(1));
    assign w_unused_lfsr = ^w_lfsr;

`ifdef BOUNCE_GEN_RANDPAIRS_EN
    generate
        if (BOUNCE_PAIRS < 1) begin : g_randpairs_check
            $error("bounce_generator: BOUNCE_PAIRS must be >= 1 with random pair count");
        end
    endgenerate

    // Pair count drawn from the high LFSR byte, always at least one pair.
    assign w_toggles_init = TOG_W'(2 * (1 + (int'(w_lfsr[15:8]) % BOUNCE_PAIRS)));
`else
    assign w_toggles_init = TOG_W'(2 * BOUNCE_PAIRS);
`endif

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = (w_change && (BOUNCE_PAIRS > 0)) ? CHATTER : SETTLE;
                end
            end
            CHATTER: begin
                if (w_last_toggle) begin
                    w_next_state = SETTLE;
                end
            end
            SETTLE: begin
                if (r_settle_cnt == SETTLE_W'(1)) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        o_Ready  = (r_state == IDLE);
        o_Busy   = (r_state == CHATTER) || (r_state == SETTLE);
        o_Done   = r_done;
        o_Bouncy = r_bouncy;
    end

    // Counters are loaded on the edge that enters a phase so each toggle
    // lands exactly one full gap after the previous edge.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_bouncy       <= INIT_LEVEL;
            r_done         <= 1'b0;
            r_gap_cnt      <= '0;
            r_toggles_left <= '0;
            r_settle_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_bouncy       <= i_Level;
                        r_gap_cnt      <= w_gap;
                        r_toggles_left <= w_toggles_init;
                        r_settle_cnt   <= SETTLE_W'(SETTLE_CYCLES);
                    end
                end
                CHATTER: begin
                    if (w_toggle) begin
                        r_bouncy       <= ~r_bouncy;
                        r_toggles_left <= r_toggles_left - TOG_W'(1);
                        r_gap_cnt      <= w_gap;
                        if (w_last_toggle) begin
                            r_settle_cnt <= SETTLE_W'(SETTLE_CYCLES);
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                SETTLE: begin
                    r_settle_cnt <= r_settle_cnt - SETTLE_W'(1);
                    if (r_settle_cnt == SETTLE_W'(1)) begin
                        r_done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bounce_generator.sv
// ============================================================================
// Module   : tb_bounce_generator
// Brief    : Directed self-checking bench for bounce_generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bounce_generator;

    localparam int          BP       = 2;
    localparam int          MG       = 2;
    localparam int          GB       = 2;
    localparam int          SC       = 8;
    localparam int          DB_LIMIT = 10;
    localparam logic        INIT     = 1'b0;
    localparam logic [15:0] SEED     = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req = 1'b0;
    logic level = 1'b0;
    logic ready, busy, done, bouncy;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lfsr;
    logic        exp_lvl;
    logic        db_out;
    int          db_cnt;
    int          db_changes = 0;
    int          edge_log[$];
    int          ref_log[$];
    int          db0;

    bounce_generator #(
        .BOUNCE_PAIRS  (BP),
        .MIN_GAP       (MG),
        .GAP_BITS      (GB),
        .SETTLE_CYCLES (SC),
        .INIT_LEVEL    (INIT),
        .LFSR_SEED     (SEED)
    ) dut (
        .i_Clk    (clk),
        .i_Rst    (rst),
        .i_Req    (req),
        .i_Level  (level),
        .o_Ready  (ready),
        .o_Busy   (busy),
        .o_Done   (done),
        .o_Bouncy (bouncy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference LFSR tracking the free-running generator cycle by cycle.
    always @(posedge clk) m_lfsr <= rst ? SEED : lfsr_next(m_lfsr);

    // Counter-style debounce filter fed by the emulated contact.
    always @(posedge clk) begin
        if (rst) begin
            db_out <= INIT;
            db_cnt <= 0;
        end else if (bouncy != db_out) begin
            if (db_cnt == DB_LIMIT - 1) begin
                db_out     <= bouncy;
                db_cnt     <= 0;
                db_changes <= db_changes + 1;
            end else begin
                db_cnt <= db_cnt + 1;
            end
        end else begin
            db_cnt <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        req = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        check("rst_bouncy", bouncy, INIT);
        check("rst_ready", ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b0;
        exp_lvl = INIT;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("idle_done", done, 1'b0);
            check("idle_ready", ready, 1'b1);
            check("idle_busy", busy, 1'b0);
            check("idle_bouncy", bouncy, exp_lvl);
        end
    endtask

    // Predicts the full edge schedule from the LFSR state before the accept
    // edge, then compares the DUT cycle by cycle. abort_at >= 0 stops early.
    task automatic do_req(input logic lvl, input bit keep_req, input int abort_at);
        logic [15:0] l;
        int          t;
        int          g;
        int          sched[$];
        int          nsched;
        int          done_t;
        logic        e;
        logic        prev;
        int          gap;
        check("req_ready", ready, 1'b1);
        l = m_lfsr;
        t = 0;
        if (lvl != exp_lvl) begin
            sched.push_back(0);
            for (int p = 0; p < 2*BP; p++) begin
                g = MG + int'(l[GB-1:0]);
                for (int s = 0; s < g; s++) l = lfsr_next(l);
                t += g;
                sched.push_back(t);
            end
        end
        nsched = sched.size();
        done_t = t + SC;
        edge_log.delete();
        e    = exp_lvl;
        prev = exp_lvl;
        req   = 1'b1;
        level = lvl;
        for (int n = 0; n <= done_t; n++) begin
            @(posedge clk);
            #1;
            if (n == 0 && !keep_req) req = 1'b0;
            if (sched.size() > 0 && sched[0] == n) begin
                e = ~e;
                void'(sched.pop_front());
            end
            check("bouncy", bouncy, e);
            check("done", done, (n == done_t));
            check("busy", busy, (n < done_t));
            check("ready", ready, (n == done_t));
            if (bouncy !== prev) edge_log.push_back(n);
            prev = bouncy;
            if (n == abort_at) return;
        end
        exp_lvl = lvl;
        check("edge_count", edge_log.size(), nsched);
        for (int i = 1; i < edge_log.size(); i++) begin
            gap = edge_log[i] - edge_log[i-1];
            check("gap_range", (gap >= MG) && (gap <= MG + 2**GB - 1), 1'b1);
        end
    endtask

    initial begin
        // Reset and quiet idle period
        do_reset(3);
        idle(100);

        // Changing request: first edge plus 2*BP chatter toggles
        do_req(1'b1, 1'b0, -1);
        check("five_edges", edge_log.size(), 5);
        check("final_level", bouncy, 1'b1);

        // Same-level request: no edges, settle only
        do_req(1'b1, 1'b0, -1);
        check("no_edges", edge_log.size(), 0);

        // Request held high: second accept lands on the done cycle
        do_req(1'b0, 1'b1, -1);
        check("held_edges", edge_log.size(), 5);
        do_req(1'b0, 1'b0, -1);
        idle(3);

        // Reset mid-chatter reseeds the LFSR and repeats the sequence
        do_reset(1);
        idle(5);
        do_req(1'b1, 1'b0, -1);
        ref_log = edge_log;
        do_req(1'b0, 1'b0, 3);
        do_reset(1);
        idle(5);
        do_req(1'b1, 1'b0, -1);
        check("rerun_count", edge_log.size(), ref_log.size());
        for (int i = 0; i < ref_log.size() && i < edge_log.size(); i++) begin
            check("rerun_edge", edge_log[i], ref_log[i]);
        end

        // Loopback through the debounce filter
        idle(12);
        check("db_pre", db_out, 1'b1);
        db0 = db_changes;
        do_req(1'b0, 1'b0, -1);
        idle(4);
        check("db_once_fall", db_changes - db0, 1);
        check("db_level_fall", db_out, 1'b0);
        db0 = db_changes;
        do_req(1'b1, 1'b0, -1);
        idle(4);
        check("db_once_rise", db_changes - db0, 1);
        check("db_level_rise", db_out, 1'b1);
        db0 = db_changes;
        do_req(1'b1, 1'b0, -1);
        idle(12);
        check("db_none_same", db_changes - db0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
